// File: rtl/rijndael_pkg.sv
// Shared types and sizing helpers for the word-serial Rijndael wrapper.
package rijndael_pkg;

    localparam int WORD = 32;

    typedef enum logic [1:0] {
        S_FILL,
        S_START,
        S_BUSY,
        S_DRAIN
    } wrapper_state_e;

    function automatic int max_words(input int nb, input int nk);
        return (nb > nk) ? nb : nk;
    endfunction

    // Round count of the core for a given state/key width.
    function automatic int nr(input int nb, input int nk);
        return max_words(nb, nk) + 6;
    endfunction

endpackage

// File: rtl/rijndael_stream_wrapper_if.sv
// Stream and core-side signals of the wrapper; slave is the wrapper, master is its environment.
interface rijndael_stream_wrapper_if #(
    parameter int NB = 4,
    parameter int NK = 4
);
    import rijndael_pkg::*;

    logic [WORD-1:0]    key_word_i;
    logic               key_valid_i;
    logic               key_ready_o;
    logic [WORD-1:0]    in_word_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [WORD-1:0]    out_word_o;
    logic               out_valid_o;
    logic               out_last_o;
    logic               out_ready_i;
    logic               core_enable_o;
    logic               core_ready_i;
    logic [WORD*NB-1:0] core_plaintext_o;
    logic [WORD*NK-1:0] core_key_o;
    logic [WORD*NB-1:0] core_ciphertext_i;

    modport slave (
        input  key_word_i, key_valid_i, in_word_i, in_valid_i, out_ready_i,
               core_ready_i, core_ciphertext_i,
        output key_ready_o, in_ready_o, out_word_o, out_valid_o, out_last_o,
               core_enable_o, core_plaintext_o, core_key_o
    );

    modport master (
        output key_word_i, key_valid_i, in_word_i, in_valid_i, out_ready_i,
               core_ready_i, core_ciphertext_i,
        input  key_ready_o, in_ready_o, out_word_o, out_valid_o, out_last_o,
               core_enable_o, core_plaintext_o, core_key_o
    );

endinterface

// File: rtl/rijndael_word_shifter.sv
// Word register with parallel load and MS-first shift; shifting in at the LS end.
module rijndael_word_shifter
    import rijndael_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WORDS*WORD-1:0] load_data,
    input  logic                  shift,
    input  logic [WORD-1:0]       word_in,
    output logic [WORDS*WORD-1:0] data
);
    localparam int W = WORDS * WORD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= (data << WORD) | W'(word_in);
        end
    end

endmodule

// File: rtl/rijndael_stream_wrapper.sv
// Word-serial front/back end for rijndael_encrypt: gathers key and plaintext words,
// starts the core, captures its one-cycle ciphertext and streams it back out.
module rijndael_stream_wrapper
    import rijndael_pkg::*;
#(
    parameter int NB = 4,
    parameter int NK = 4
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    rijndael_stream_wrapper_if.slave bus
);
    localparam int STATESIZE = WORD * NB;
    localparam int KEYSIZE   = WORD * NK;
    localparam int CW        = $clog2(max_words(NB, NK)) + 1;
    localparam logic [CW-1:0] NB_FULL = CW'(NB);
    localparam logic [CW-1:0] NB_LAST = CW'(NB - 1);
    localparam logic [CW-1:0] NK_LAST = CW'(NK - 1);

    wrapper_state_e       state;
    logic [CW-1:0]        key_cnt;
    logic [CW-1:0]        pt_cnt;
    logic [CW-1:0]        out_cnt;
    logic                 key_loaded;
    logic                 key_fire;
    logic                 pt_fire;
    logic                 out_fire;
    logic                 capture;
    logic [KEYSIZE-1:0]   key_reg;
    logic [STATESIZE-1:0] pt_reg;
    logic [STATESIZE-1:0] out_reg;

    // Handshake outputs are pure decodes of registered state and counters.
    assign bus.key_ready_o      = (state == S_FILL);
    assign bus.in_ready_o       = ((state == S_FILL) || (state == S_DRAIN)) && (pt_cnt < NB_FULL);
    assign bus.core_enable_o    = (state == S_START);
    assign bus.out_valid_o      = (state == S_DRAIN);
    assign bus.out_last_o       = (state == S_DRAIN) && (out_cnt == NB_LAST);
    assign bus.out_word_o       = out_reg[STATESIZE-1 -: WORD];
    assign bus.core_plaintext_o = pt_reg;
    assign bus.core_key_o       = key_reg;

    assign key_fire = bus.key_valid_i && bus.key_ready_o;
    assign pt_fire  = bus.in_valid_i && bus.in_ready_o;
    assign out_fire = bus.out_valid_o && bus.out_ready_i;
    assign capture  = (state == S_BUSY) && bus.core_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_FILL;
            key_cnt    <= '0;
            pt_cnt     <= '0;
            out_cnt    <= '0;
            key_loaded <= 1'b0;
        end else begin
            // A reload restarting at word 0 invalidates the held key until it wraps again.
            if (key_fire) begin
                if (key_cnt == NK_LAST) begin
                    key_cnt    <= '0;
                    key_loaded <= 1'b1;
                end else begin
                    key_cnt <= key_cnt + 1'b1;
                    if (key_cnt == '0) key_loaded <= 1'b0;
                end
            end
            if (pt_fire) pt_cnt <= pt_cnt + 1'b1;

            case (state)
                S_FILL: begin
                    if ((pt_cnt == NB_FULL) && key_loaded && !key_fire) state <= S_START;
                end
                S_START: begin
                    if (bus.core_ready_i) state <= S_BUSY;
                end
                S_BUSY: begin
                    if (bus.core_ready_i) begin
                        pt_cnt  <= '0;
                        out_cnt <= '0;
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (out_cnt == NB_LAST) state <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    rijndael_word_shifter #(.WORDS(NK)) u_key (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (1'b0),
        .load_data ('0),
        .shift     (key_fire),
        .word_in   (bus.key_word_i),
        .data      (key_reg)
    );

    rijndael_word_shifter #(.WORDS(NB)) u_pt (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (1'b0),
        .load_data ('0),
        .shift     (pt_fire),
        .word_in   (bus.in_word_i),
        .data      (pt_reg)
    );

    // The core's ciphertext is only valid on its first ready cycle, hence the load on capture.
    rijndael_word_shifter #(.WORDS(NB)) u_ct (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (capture),
        .load_data (bus.core_ciphertext_i),
        .shift     (out_fire),
        .word_in   ('0),
        .data      (out_reg)
    );

endmodule
